// File: rtl/port_uart_tx_pkg.sv
// port_uart_tx_pkg: FSM states and port_out/port_in bit positions shared by the UART TX slice
package port_uart_tx_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;
  localparam int BUSY    = 0;
  localparam int FULL    = 1;
  localparam int OVF     = 2;
  localparam int ACK     = 8;
  localparam int TOG     = 8;
  localparam int OVF_CLR = 9;
endpackage

// File: rtl/port_uart_tx_fifo.sv
// uart_fifo: circular byte FIFO (CLK, reset, push, pop, din -> dout, empty, full); push while full is taken only alongside a pop
module uart_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_BITS = 2
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  logic [WIDTH-1:0] mem [2**DEPTH_BITS];
  logic [DEPTH_BITS-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_BITS:0] count, count_nxt;
  logic wr_en, rd_en;
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign count_nxt = count + (DEPTH_BITS+1)'(wr_en) - (DEPTH_BITS+1)'(rd_en);
  assign dout = mem[rd_ptr];
  always_ff @(posedge CLK)
    if (wr_en) mem[wr_ptr] <= din;
  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + DEPTH_BITS'(wr_en);
      rd_ptr <= rd_ptr + DEPTH_BITS'(rd_en);
      count  <= count_nxt;
      empty  <= count_nxt == '0;
      full   <= count_nxt[DEPTH_BITS];
    end
  end
endmodule

// File: rtl/port_uart_tx.sv
// port_uart_tx: toggle-strobed byte queue on port_out serialized as 8N1 on TX; busy/full/overflow/ack reported on port_in
module port_uart_tx
  import port_uart_tx_pkg::*;
#(
  parameter int WIDTH_REG       = 32,
  parameter int CLKS_PER_BIT    = 104,
  parameter int FIFO_DEPTH_BITS = 2
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic [WIDTH_REG-1:0] port_out,
  output logic [WIDTH_REG-1:0] port_in,
  output logic                 TX
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  state_t state;
  logic [CW-1:0] baud;
  logic [2:0] bit_idx;
  logic [7:0] shift_reg, dout;
  logic tog_q, ack_q, ovf_q, busy_q;
  logic push_req, pop, accept, drop, bit_end, empty, full, idle_next, unused;
  assign unused    = ^port_out;
  assign push_req  = port_out[TOG] != tog_q;
  assign pop       = state == IDLE && !empty;
  assign accept    = push_req && (!full || pop);
  assign drop      = push_req && !accept;
  assign bit_end   = baud == CW'(CLKS_PER_BIT-1);
  // busy is registered, so it is derived from where state and FIFO land after this edge
  assign idle_next = (state == IDLE || (state == STOP && bit_end)) && empty && !accept;
  uart_fifo #(.WIDTH(8), .DEPTH_BITS(FIFO_DEPTH_BITS)) u_fifo (
    .CLK(CLK), .reset(reset), .push(push_req), .pop(pop),
    .din(port_out[7:0]), .dout(dout), .empty(empty), .full(full)
  );
  always_comb begin
    port_in       = '0;
    port_in[BUSY] = busy_q;
    port_in[FULL] = full;
    port_in[OVF]  = ovf_q;
    port_in[ACK]  = ack_q;
  end
  always_ff @(posedge CLK) begin
    tog_q <= port_out[TOG];
    if (reset) begin
      ack_q  <= port_out[TOG];
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      ack_q  <= accept ? port_out[TOG] : ack_q;
      ovf_q  <= drop || (ovf_q && !port_out[OVF_CLR]);
      busy_q <= !idle_next;
    end
  end
  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= IDLE;
      TX        <= 1'b1;
      baud      <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      baud <= bit_end ? '0 : baud + CW'(1);
      case (state)
        IDLE: begin
          baud <= '0;
          if (!empty) begin
            shift_reg <= dout;
            state     <= START;
            TX        <= 1'b0;
          end
        end
        START: if (bit_end) begin
          state   <= DATA;
          TX      <= shift_reg[0];
          bit_idx <= '0;
        end
        DATA: if (bit_end) begin
          shift_reg <= shift_reg >> 1;
          bit_idx   <= bit_idx + 3'd1;
          state     <= bit_idx == 3'd7 ? STOP : DATA;
          TX        <= bit_idx == 3'd7 ? 1'b1 : shift_reg[1];
        end
        STOP: if (bit_end) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_port_uart_tx.sv
// tb_port_uart_tx: directed checks of framing, queueing, overflow, same-cycle push/pop and reset on port_uart_tx
module tb_port_uart_tx;
  localparam int CPB   = 4;
  localparam int FRAME = 10*CPB + 1;
  logic CLK = 1'b0;
  logic reset = 1'b1;
  logic [31:0] port_out = '0;
  logic [31:0] port_in;
  logic TX;
  logic tog = 1'b0;
  logic ack5;
  logic [7:0] bq [8];
  int n_chk = 0;
  int n_fail = 0;
  port_uart_tx #(.WIDTH_REG(32), .CLKS_PER_BIT(CPB), .FIFO_DEPTH_BITS(2)) dut (
    .CLK(CLK), .reset(reset), .port_out(port_out), .port_in(port_in), .TX(TX)
  );
  always #5 CLK = ~CLK;
  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  function automatic logic fbit(input logic [7:0] d, input int k);
    return k == 0 ? 1'b0 : k == 9 ? 1'b1 : d[k-1];
  endfunction
  task automatic drive(input logic [7:0] d);
    tog = ~tog;
    port_out = {22'd0, 1'b0, tog, d};
  endtask
  task automatic run(input int ndrive, input int nf, input int lead, input bit chk_full);
    int last;
    last = lead + FRAME*nf - 1;
    for (int c = 0; c <= last; c++) begin
      int rel;
      rel = c - lead;
      check("tx", TX, (rel < 0 || rel % FRAME == FRAME-1) ? 1'b1 : fbit(bq[rel/FRAME], (rel % FRAME)/CPB));
      check("busy", port_in[0], rel >= -1 && rel <= FRAME*nf - 2);
      if (chk_full) check("full_zero", port_in[1], 0);
      if (c >= 1 && c <= ndrive) check("ack", port_in[8], tog);
      if (c < ndrive) drive(bq[c]);
      if (c < last) step(1);
    end
  endtask
  initial begin
    step(4);
    check("rst_port_in", port_in, 0);
    check("rst_tx", TX, 1);
    reset = 1'b0;
    step(2);
    check("idle_port_in", port_in, 0);
    check("idle_tx", TX, 1);
    bq[0] = 8'h55;
    run(1, 1, 2, 1'b1);
    bq[0] = 8'h01; bq[1] = 8'h02; bq[2] = 8'h03; bq[3] = 8'h04;
    run(4, 4, 2, 1'b1);
    for (int i = 0; i < 6; i++) begin
      drive(8'(8'h11 * (i + 1)));
      if (i == 4) ack5 = tog;
      step(1);
      if (i == 4) begin
        check("full_after5", port_in[1], 1);
        check("ovf_after5", port_in[2], 0);
      end
    end
    check("ovf_set", port_in[2], 1);
    check("ovf_ack5", port_in[8], ack5);
    check("ovf_full", port_in[1], 1);
    port_out[9] = 1'b1;
    step(1);
    check("ovf_clr", port_in[2], 0);
    port_out[9] = 1'b0;
    step(35);
    check("gap_tx", TX, 1);
    check("gap_full", port_in[1], 1);
    drive(8'h77);
    step(1);
    check("pp_full", port_in[1], 1);
    check("pp_ovf", port_in[2], 0);
    check("pp_ack", port_in[8], tog);
    bq[0] = 8'h22; bq[1] = 8'h33; bq[2] = 8'h44; bq[3] = 8'h55; bq[4] = 8'h77;
    run(0, 5, 0, 1'b0);
    reset = 1'b1;
    port_out = '0;
    tog = 1'b0;
    step(2);
    check("rst2_port_in", port_in, 0);
    reset = 1'b0;
    step(1);
    drive(8'hA5);
    step(14);
    check("mid_bit2", TX, 1);
    step(5);
    check("mid_bit3", TX, 0);
    reset = 1'b1;
    port_out = '0;
    tog = 1'b0;
    step(1);
    check("abort_tx", TX, 1);
    check("abort_port_in", port_in, 0);
    reset = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step(1);
      check("quiet_tx", TX, 1);
      check("quiet_port_in", port_in, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
